adc_scan_ctrl: RTL

- Sequencer for the on-board ADC128S022 8-channel serial ADC (ADC_CS_N / ADC_SADDR / ADC_SCLK / ADC_SDAT pins).
- Continuously scans the channels enabled in CH_MASK and generates SCLK, CS and the address stream.
- Captures each 12-bit result and presents it as a one-cycle valid pulse tagged with its channel.
- Sits in the top-level wrapper on clk20M; consumers include audio/paddle input logic and debug LEDs.

---
 rtl/adc_pkg.sv | 35 +++
 rtl/adc_scan_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/adc_pkg.sv
// Shared types, frame constants and channel-rotation helper for the ADC128S022 scan controller.
package adc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOW,
    HIGH,
    DONE
  } adc_state_t;

  localparam int unsigned ADC_FRAME_BITS     = 16;
  localparam int unsigned ADC_DATA_BITS      = 12;
  localparam int unsigned ADC_ADDR_FIRST_BIT = 2;
  localparam int unsigned ADC_CH_BITS        = 3;

  // Next enabled channel strictly after cur, wrapping 7->0; an empty mask means channel 0 only.
  function automatic logic [ADC_CH_BITS-1:0] next_ch(input logic [ADC_CH_BITS-1:0] cur,
                                                     input logic [7:0] mask);
    logic [7:0]             m;
    logic [ADC_CH_BITS-1:0] c;
    logic                   found;
    m       = (mask == 8'h00) ? 8'h01 : mask;
    next_ch = cur;
    found   = 1'b0;
    for (int unsigned i = 1; i <= 8; i++) begin
      c = cur + ADC_CH_BITS'(i);
      if (!found && m[c]) begin
        next_ch = c;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/adc_scan_ctrl.sv
// Continuous channel scanner for the ADC128S022: generates CS/SCLK/DIN and
// emits each 12-bit result tagged with the channel it was converted from.
module adc_scan_ctrl
  import adc_pkg::*;
#(
  parameter int unsigned DIV     = 4,
  parameter logic [7:0]  CH_MASK = 8'hFF
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic                     en,
  output logic                     adc_cs_n,
  output logic                     adc_sclk,
  output logic                     adc_saddr,
  input  logic                     adc_sdat,
  output logic [ADC_DATA_BITS-1:0] sample,
  output logic [ADC_CH_BITS-1:0]   sample_ch,
  output logic                     sample_valid,
  output logic                     busy
);

  localparam int unsigned            PH_W     = 8;
  localparam logic [PH_W-1:0]        PH_LAST  = PH_W'(DIV - 1);
  localparam logic [3:0]             B_LAST   = 4'(ADC_FRAME_BITS - 1);
  localparam logic [ADC_CH_BITS-1:0] CH_FIRST = next_ch(3'd7, CH_MASK);

  adc_state_t                 state_q;
  logic [PH_W-1:0]            ph_q;
  logic [3:0]                 b_q;
  // Most recent 11 DOUT bits; the 12th joins directly at capture, leading bits fall off the top.
  logic [ADC_DATA_BITS-2:0]   data_q;
  logic [ADC_CH_BITS-1:0]     cur_ch_q;
  logic [ADC_CH_BITS-1:0]     prev_ch_q;
  logic                       first_q;
  logic                       cs_n_q;
  logic                       sclk_q;
  logic                       saddr_q;
  logic [ADC_DATA_BITS-1:0]   sample_q;
  logic [ADC_CH_BITS-1:0]     sample_ch_q;
  logic                       valid_q;
  logic                       busy_q;

  logic                       ph_last_c;
  logic [3:0]                 b_d;

  // DIN value for the LOW phase of bit b: channel address MSB first in bits 2..4.
  function automatic logic addr_bit(input logic [3:0] b, input logic [ADC_CH_BITS-1:0] ch);
    case (b)
      4'(ADC_ADDR_FIRST_BIT):     addr_bit = ch[2];
      4'(ADC_ADDR_FIRST_BIT + 1): addr_bit = ch[1];
      4'(ADC_ADDR_FIRST_BIT + 2): addr_bit = ch[0];
      default:                    addr_bit = 1'b0;
    endcase
  endfunction

  // Phase-end and next bit index helpers.
  always_comb begin
    ph_last_c = (ph_q == PH_LAST);
    b_d       = b_q + 4'd1;
  end

  // Frame sequencer with registered pin and result outputs.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= IDLE;
      ph_q        <= '0;
      b_q         <= '0;
      data_q      <= '0;
      cur_ch_q    <= CH_FIRST;
      prev_ch_q   <= '0;
      first_q     <= 1'b1;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b1;
      saddr_q     <= 1'b0;
      sample_q    <= '0;
      sample_ch_q <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          ph_q <= '0;
          if (en) begin
            state_q <= SETUP;
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            first_q <= 1'b1;
          end
        end
        SETUP: begin
          if (ph_last_c) begin
            ph_q    <= '0;
            b_q     <= '0;
            state_q <= LOW;
            sclk_q  <= 1'b0;
            saddr_q <= addr_bit(4'd0, cur_ch_q);
          end else begin
            ph_q <= ph_q + 8'd1;
          end
        end
        LOW: begin
          if (ph_last_c) begin
            ph_q    <= '0;
            state_q <= HIGH;
            sclk_q  <= 1'b1;
          end else begin
            ph_q <= ph_q + 8'd1;
          end
        end
        HIGH: begin
          if (ph_last_c) begin
            ph_q   <= '0;
            data_q <= {data_q[ADC_DATA_BITS-3:0], adc_sdat};
            if (b_q != B_LAST) begin
              b_q     <= b_d;
              state_q <= LOW;
              sclk_q  <= 1'b0;
              saddr_q <= addr_bit(b_d, cur_ch_q);
            end else begin
              // Frame end: publish the previous frame's channel, advance the rotation.
              state_q <= DONE;
              cs_n_q  <= 1'b1;
              saddr_q <= 1'b0;
              if (!first_q) begin
                valid_q     <= 1'b1;
                sample_q    <= {data_q, adc_sdat};
                sample_ch_q <= prev_ch_q;
              end
              prev_ch_q <= cur_ch_q;
              cur_ch_q  <= next_ch(cur_ch_q, CH_MASK);
              first_q   <= 1'b0;
            end
          end else begin
            ph_q <= ph_q + 8'd1;
          end
        end
        DONE: begin
          if (ph_last_c) begin
            ph_q <= '0;
            if (en) begin
              state_q <= SETUP;
              cs_n_q  <= 1'b0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            ph_q <= ph_q + 8'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          ph_q    <= '0;
          cs_n_q  <= 1'b1;
          sclk_q  <= 1'b1;
          saddr_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign adc_cs_n     = cs_n_q;
  assign adc_sclk     = sclk_q;
  assign adc_saddr    = saddr_q;
  assign sample       = sample_q;
  assign sample_ch    = sample_ch_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;

endmodule
